// File: rtl/qam16_frame_tx_if.sv
// Symbol-rate control and I/Q output bundle for qam16_frame_tx.
// Handshake: start is a level request sampled only on clk_en edges; every output is registered and changes only on those edges.
interface qam16_frame_tx_if;
    logic               clk_en;
    logic               start;
    logic signed [17:0] i_out;
    logic signed [17:0] q_out;
    logic [3:0]         sym_out;
    logic               frame_sync;
    logic               payload_valid;
    logic               busy;
    logic [1:0]         fsm_state;

    modport master (
        input  clk_en, start,
        output i_out, q_out, sym_out, frame_sync, payload_valid, busy, fsm_state
    );

    modport slave (
        output clk_en, start,
        input  i_out, q_out, sym_out, frame_sync, payload_valid, busy, fsm_state
    );
endinterface

// File: rtl/qam16_frame_tx.sv
// 16-QAM frame source: calibration preamble, LFSR payload, silent gap.
// Define QAM_TX_PREAMBLE_EN to include the preamble; without it frames start directly with payload.
module qam16_frame_tx #(
    parameter int                 PREAMBLE_LEN = 64,
    parameter int                 PAYLOAD_LEN  = 1024,
    parameter int                 GAP_LEN      = 16,
    parameter logic signed [17:0] AMP_A        = 18'sd32768,
    parameter logic [21:0]        LFSR_SEED    = 22'h000001
) (
    input  logic              clk,
    input  logic              reset,
    qam16_frame_tx_if.master  bus
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;

    localparam int CNT_W = $clog2(PREAMBLE_LEN + PAYLOAD_LEN + GAP_LEN + 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);
`ifdef QAM_TX_PREAMBLE_EN
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
`endif
    localparam logic signed [17:0] AMP_3A = (AMP_A <<< 1) + AMP_A;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [21:0]      lfsr, lfsr_n, lfsr_adv;
    logic [3:0]       sym_n;
    logic             fs_n, pv_n, on_air_n, launch;

    function automatic logic signed [17:0] gray_level(input logic [1:0] b);
        case (b)
            2'b00:   return -AMP_3A;
            2'b01:   return -AMP_A;
            2'b11:   return AMP_A;
            default: return AMP_3A;
        endcase
    endfunction

    assign lfsr_adv      = {lfsr[20:0], lfsr[21] ^ lfsr[20]};
    assign bus.fsm_state = state;

    // cnt is the index of the symbol currently on the outputs within its state.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        lfsr_n   = lfsr;
        sym_n    = 4'b0000;
        fs_n     = 1'b0;
        pv_n     = 1'b0;
        on_air_n = 1'b0;
        launch   = 1'b0;
        case (state)
            IDLE: launch = bus.start;
`ifdef QAM_TX_PREAMBLE_EN
            PREAMBLE: begin
                on_air_n = 1'b1;
                if (cnt == PRE_LAST) begin
                    state_n = PAYLOAD;
                    cnt_n   = '0;
                    sym_n   = lfsr[3:0];
                    lfsr_n  = lfsr_adv;
                    pv_n    = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                    sym_n = cnt[0] ? 4'b1010 : 4'b0000;
                end
            end
`endif
            PAYLOAD: begin
                if (cnt == PAY_LAST) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n    = cnt + 1'b1;
                    sym_n    = lfsr[3:0];
                    lfsr_n   = lfsr_adv;
                    pv_n     = 1'b1;
                    on_air_n = 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    launch  = bus.start;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Launch overrides the IDLE/GAP defaults so back-to-back frames need no idle symbol.
        if (launch) begin
            cnt_n    = '0;
            fs_n     = 1'b1;
            on_air_n = 1'b1;
`ifdef QAM_TX_PREAMBLE_EN
            state_n  = PREAMBLE;
            sym_n    = 4'b1010;
`else
            state_n  = PAYLOAD;
            sym_n    = lfsr[3:0];
            lfsr_n   = lfsr_adv;
            pv_n     = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            lfsr              <= LFSR_SEED;
            bus.sym_out       <= 4'b0000;
            bus.i_out         <= '0;
            bus.q_out         <= '0;
            bus.frame_sync    <= 1'b0;
            bus.payload_valid <= 1'b0;
            bus.busy          <= 1'b0;
        end else if (bus.clk_en) begin
            state             <= state_n;
            cnt               <= cnt_n;
            lfsr              <= lfsr_n;
            bus.sym_out       <= sym_n;
            bus.i_out         <= on_air_n ? gray_level(sym_n[3:2]) : 18'sd0;
            bus.q_out         <= on_air_n ? gray_level(sym_n[1:0]) : 18'sd0;
            bus.frame_sync    <= fs_n;
            bus.payload_valid <= pv_n;
            bus.busy          <= (state_n != IDLE);
        end
    end

endmodule

// File: doc/qam16_frame_tx.md
# qam16_frame_tx

Transmit-side 16-QAM frame source. It emits framed I/Q symbols: a known calibration preamble, then an LFSR-driven payload, then a silent gap. These feed the channel/DAC path so the receive chain can train its reference level and measure MER and symbol errors against a known sequence. It advances one symbol per `clk_en` (the symbol-rate enable) on the system clock.

## Interface
Parameters:
- `PREAMBLE_LEN`, 64 — preamble symbols per frame (≥2, even)
- `PAYLOAD_LEN`, 1024 — payload symbols per frame (≥1)
- `GAP_LEN`, 16 — zero-output symbols after payload (≥1)
- `AMP_A`, 18'sd32768 — inner level A (1s17, 0.25); outer level is 3A
- `LFSR_SEED`, 22'h000001 — nonzero LFSR reset value

Ports (clock and reset first):
- `clk` in 1 — system clock
- `reset` in 1 — asynchronous, active-high
- `clk_en` in 1 — symbol enable, one `clk` cycle wide
- `start` in 1 — level request to transmit frames
- `i_out` out 18 signed — in-phase symbol, 1s17
- `q_out` out 18 signed — quadrature symbol, 1s17
- `sym_out` out 4 — symbol bits; [3:2] select I, [1:0] select Q
- `frame_sync` out 1 — high during the first symbol of each frame
- `payload_valid` out 1 — high while payload symbols are on the outputs
- `busy` out 1 — high in any state other than IDLE

## Operation
- FSM states: IDLE, PREAMBLE, PAYLOAD, GAP. All state changes, counter updates and output updates occur only on `clk` edges where `clk_en`=1.
- IDLE: outputs are I=Q=0 and `sym_out`=0. If `start`=1 → PREAMBLE, and preamble symbol 0 is driven at that same edge.
- PREAMBLE: index k counts 0..PREAMBLE_LEN-1.
  - Even k: `sym_out`=4'b1010, I=Q=+3A.
  - Odd k: `sym_out`=4'b0000, I=Q=−3A.
  - After the last k → PAYLOAD.
- PAYLOAD: PAYLOAD_LEN symbols.
  - `sym_out` = `lfsr[3:0]`, sampled before the advance.
  - The LFSR then advances once: 22-bit Fibonacci, shift left, `lfsr[0]` ← `lfsr[21]^lfsr[20]`.
  - After the last symbol → GAP.
- GAP: GAP_LEN symbols with I=Q=0 and `sym_out`=0. At the end, `start`=1 → PREAMBLE (back-to-back frame); otherwise → IDLE.
- Gray map per 2-bit field: 00→−3A, 01→−A, 11→+A, 10→+3A.
  - I is driven from `sym_out[3:2]`; Q from `sym_out[1:0]`.
  - 3A is computed as `(AMP_A<<1)+AMP_A` in 18 bits. No saturation; the parameter range guarantees 3A < 2^17.
- LFSR state persists across frames and is reloaded only by `reset`. Consecutive frames therefore carry different payloads.
- Deasserting `start` mid-frame does not truncate the frame; the frame completes through GAP.
- `frame_sync` is high for the first symbol of a frame: PREAMBLE k=0, or the first PAYLOAD symbol when the preamble is compiled out.
- `payload_valid` is high exactly while PAYLOAD symbols are driven.

## Timing
- All outputs are registered and hold their value between `clk_en` edges.
- Latency: `start` sampled on a `clk_en` edge → first frame symbol valid immediately after that edge. That is 0 symbol periods, or 1 `clk` cycle from the sampling edge.
- Frame length is PREAMBLE_LEN+PAYLOAD_LEN+GAP_LEN symbol periods.
- Back-to-back frames have no extra IDLE symbol.
- Reset values: state IDLE, `i_out`=`q_out`=0, `sym_out`=0, `frame_sync`=0, `payload_valid`=0, `busy`=0, `lfsr`=LFSR_SEED, counters 0.
- Reset mid-frame: immediate asynchronous return to the reset values. The next frame restarts from LFSR_SEED.
- `clk_en` low: no state or output change, regardless of `start`.

## Configuration
- `QAM_TX_PREAMBLE_EN` defined: the PREAMBLE state is present, as described above.
- `QAM_TX_PREAMBLE_EN` undefined: the PREAMBLE state is removed and the IDLE/GAP exits go directly to PAYLOAD. `frame_sync` marks the first payload symbol, and frame length is PAYLOAD_LEN+GAP_LEN.

## Test plan
- Reset, then `start`=1 with defaults → preamble k=0 gives I=Q=+98304, `sym_out`=1010, `frame_sync`=1; k=1 gives I=Q=−98304, `frame_sync`=0.
- After 64 preamble symbols → first payload symbol is `sym_out`=0001 (I=−98304, Q=−32768), then 0010 (I=−98304, Q=+98304), then 0100; `payload_valid`=1 throughout the payload.
- `start` held high → after 1024 payload symbols and 16 zero gap symbols, `frame_sync` reasserts with no IDLE symbol between frames. The second frame's first payload symbol ≠ 0001 (LFSR continues).
- `start` pulsed for one `clk_en` only → exactly one frame of 1104 symbols, then IDLE with `busy`=0 and outputs 0.
- `reset` asserted mid-payload between `clk_en` edges → outputs go to 0 without waiting for a clock edge. After release and `start`, the payload again begins at `sym_out`=0001.
- Build without `QAM_TX_PREAMBLE_EN` → the first symbol after `start` is `sym_out`=0001 with `frame_sync`=1 and `payload_valid`=1; frame length is 1040 symbols.
